// File: rtl/chip_pkg.sv
// Constants and types shared by the chip_tx transmitter and the chip receiver.
package chip_pkg;

  localparam int CHIP_DATA_W = 32;
  localparam int CHIP_LANE_W = 4;

  typedef enum logic {IDLE, SEND} chip_tx_state_t;

endpackage

// File: rtl/chip_tx_nibble_shreg.sv
// One lane of chip_tx: loadable word register that shifts right by LANE_W per accepted beat.
// With CHIP_TX_PARITY_EN, also keeps the parity of the nibble it presents.
module nibble_shreg
  import chip_pkg::*;
#(
  parameter int DATA_W = CHIP_DATA_W,
  parameter int LANE_W = CHIP_LANE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] d,
  output logic [LANE_W-1:0] lane
`ifdef CHIP_TX_PARITY_EN
  ,
  output logic              par
`endif
);

  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] q_sh;

  assign q_sh = q >> LANE_W;
  assign lane = q[LANE_W-1:0];

  // load wins over shift so a back-to-back frame replaces the finished one
  always_ff @(posedge clk) begin
    if (!rst_n)     q <= '0;
    else if (load)  q <= d;
    else if (shift) q <= q_sh;
  end

`ifdef CHIP_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n)     par <= 1'b0;
    else if (load)  par <= ^d[LANE_W-1:0];
    else if (shift) par <= ^q_sh[LANE_W-1:0];
  end
`endif

endmodule

// File: rtl/chip_tx.sv
// Nibble-lane transmitter: loads an LSB/MSB word pair and streams both words LS nibble first.
// Optional CHIP_TX_PARITY_EN adds the pParity output.
module chip_tx
  import chip_pkg::*;
#(
  parameter int DATA_W = CHIP_DATA_W,
  parameter int LANE_W = CHIP_LANE_W
) (
  input  logic              pclk,
  input  logic              RESET_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_value_LSBs,
  input  logic [DATA_W-1:0] in_value_MSBs,
  output logic [LANE_W-1:0] LSBs,
  output logic [LANE_W-1:0] MSBs,
  output logic              pValid,
  input  logic              pReady,
  output logic              tx_done
`ifdef CHIP_TX_PARITY_EN
  ,
  output logic              pParity
`endif
);

  localparam int BEATS = DATA_W / LANE_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  chip_tx_state_t state, state_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic xfer, last_beat, load;

  logic [1:0][DATA_W-1:0] words;
  logic [1:0][LANE_W-1:0] lanes;

  assign xfer      = pValid && pReady;
  assign last_beat = xfer && (beat_cnt == LAST);
  assign load      = in_valid && in_ready;

  always_ff @(posedge pclk) begin
    if (!RESET_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SEND;
      SEND:    if (last_beat && !load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready reopens on the last accepted beat so frames run without a bubble
  always_comb begin
    pValid   = (state == SEND);
    in_ready = RESET_n && ((state == IDLE) || last_beat);
  end

  always_ff @(posedge pclk) begin
    if (!RESET_n) begin
      beat_cnt <= '0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= last_beat;
      if (load)      beat_cnt <= '0;
      else if (xfer) beat_cnt <= beat_cnt + 1'b1;
    end
  end

  assign words[0] = in_value_LSBs;
  assign words[1] = in_value_MSBs;

`ifdef CHIP_TX_PARITY_EN
  logic [1:0] par;
  assign pParity = ^par;
`endif

  for (genvar i = 0; i < 2; i++) begin : g_lane
    nibble_shreg #(.DATA_W(DATA_W), .LANE_W(LANE_W)) u_shreg (
      .clk   (pclk),
      .rst_n (RESET_n),
      .load  (load),
      .shift (xfer),
      .d     (words[i]),
      .lane  (lanes[i])
`ifdef CHIP_TX_PARITY_EN
      ,
      .par   (par[i])
`endif
    );
  end

  assign LSBs = lanes[0];
  assign MSBs = lanes[1];

endmodule

// File: tb/tb_chip_tx.sv
// Scoreboard bench for chip_tx: expected beats queued at load, compared as beats are accepted.
// Parity checks run when CHIP_TX_PARITY_EN is defined.
module tb_chip_tx;

  localparam int DW = 32;
  localparam int LW = 4;

  logic          pclk = 1'b0;
  logic          RESET_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_value_LSBs = '0;
  logic [DW-1:0] in_value_MSBs = '0;
  logic [LW-1:0] LSBs, MSBs;
  logic          pValid;
  logic          pReady = 1'b0;
  logic          tx_done;
  logic          par;

`ifdef CHIP_TX_PARITY_EN
  logic pParity;
  assign par = pParity;
`else
  assign par = 1'b0;
`endif

  always #5 pclk = ~pclk;

  chip_tx dut (
    .pclk          (pclk),
    .RESET_n       (RESET_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_value_LSBs (in_value_LSBs),
    .in_value_MSBs (in_value_MSBs),
    .LSBs          (LSBs),
    .MSBs          (MSBs),
    .pValid        (pValid),
    .pReady        (pReady),
    .tx_done       (tx_done)
`ifdef CHIP_TX_PARITY_EN
    ,
    .pParity       (pParity)
`endif
  );

  typedef struct {logic [3:0] l; logic [3:0] m;} beat_t;
  typedef struct {logic v; logic r; logic d; logic ir; logic p; logic [3:0] l; logic [3:0] m;} log_t;

  beat_t sb[$];
  log_t  lg[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic push_frame(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 8; i++) sb.push_back('{l: a[4*i +: 4], m: b[4*i +: 4]});
  endtask

  // one entry per cycle, sampled mid-cycle; returns just after the next rising edge
  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge pclk);
      lg.push_back('{v: pValid, r: pReady, d: tx_done, ir: in_ready, p: par, l: LSBs, m: MSBs});
      @(posedge pclk); #1;
    end
  endtask

  task automatic test_reset();
    RESET_n = 1'b0; in_valid = 1'b1; pReady = 1'b1;
    in_value_LSBs = 32'hFFFF_FFFF; in_value_MSBs = 32'hFFFF_FFFF;
    repeat (2) @(posedge pclk);
    #1;
    lg.delete();
    capture(1);
    n_checks++;
    if ({lg[0].v, lg[0].d, lg[0].p, lg[0].l, lg[0].m} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs v=%b d=%b p=%b l=%h m=%h expected all 0",
               lg[0].v, lg[0].d, lg[0].p, lg[0].l, lg[0].m);
    end
    n_checks++;
    if (lg[0].ir !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready got %b expected 0", lg[0].ir);
    end
    in_valid = 1'b0; RESET_n = 1'b1;
    lg.delete();
    capture(1);
    n_checks++;
    if (lg[0].ir !== 1'b1 || lg[0].v !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset in_ready=%b pValid=%b expected 1/0", lg[0].ir, lg[0].v);
    end
  endtask

  task automatic test_single_frame();
    int nv, nd, fv, di;
    beat_t e;
    lg.delete(); sb.delete();
    in_value_LSBs = 32'h8765_4321; in_value_MSBs = 32'hFEDC_BA98;
    in_valid = 1'b1; pReady = 1'b1;
    push_frame(in_value_LSBs, in_value_MSBs);
    capture(1);
    in_valid = 1'b0;
    capture(10);
    nv = 0; nd = 0; fv = -1; di = -1;
    foreach (lg[i]) begin
      if (lg[i].v) begin nv++; if (fv < 0) fv = i; end
      if (lg[i].d) begin nd++; di = i; end
      if (lg[i].v && lg[i].r) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL single_extra_beat at cycle %0d l=%h m=%h", i, lg[i].l, lg[i].m);
        end else begin
          e = sb.pop_front();
          if (lg[i].l !== e.l || lg[i].m !== e.m) begin
            n_fail++; $display("FAIL single_beat cycle %0d got %h/%h expected %h/%h", i, lg[i].l, lg[i].m, e.l, e.m);
          end
        end
      end
    end
    n_checks++;
    if (fv !== 1 || nv !== 8) begin
      n_fail++; $display("FAIL single_latency first_valid=%0d count=%0d expected 1/8", fv, nv);
    end
    n_checks++;
    if (nd !== 1 || di !== 9) begin
      n_fail++; $display("FAIL single_tx_done pulses=%0d at=%0d expected 1 at 9", nd, di);
    end
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++; $display("FAIL single_missing_beats left=%0d expected 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int nv, nd, gap;
    int dpos[$];
    beat_t e;
    lg.delete(); sb.delete();
    in_value_LSBs = 32'h1357_9BDF; in_value_MSBs = 32'h0246_8ACE;
    in_valid = 1'b1; pReady = 1'b1;
    push_frame(in_value_LSBs, in_value_MSBs);
    capture(1);
    in_value_LSBs = 32'hA5C3_0F96; in_value_MSBs = 32'h5A3C_F069;
    push_frame(in_value_LSBs, in_value_MSBs);
    capture(8);
    in_valid = 1'b0;
    capture(10);
    nv = 0; nd = 0; gap = 0;
    foreach (lg[i]) begin
      if (lg[i].v) nv++;
      if (i >= 1 && i <= 16 && !lg[i].v) gap++;
      if (lg[i].d) begin nd++; dpos.push_back(i); end
      if (lg[i].v && lg[i].r) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra_beat at cycle %0d", i);
        end else begin
          e = sb.pop_front();
          if (lg[i].l !== e.l || lg[i].m !== e.m) begin
            n_fail++; $display("FAIL b2b_beat cycle %0d got %h/%h expected %h/%h", i, lg[i].l, lg[i].m, e.l, e.m);
          end
        end
      end
    end
    n_checks++;
    if (nv !== 16 || gap !== 0) begin
      n_fail++; $display("FAIL b2b_valid_run count=%0d gaps=%0d expected 16/0", nv, gap);
    end
    n_checks++;
    if (nd !== 2 || dpos.size() != 2 || dpos[0] != 9 || dpos[1] != 17) begin
      n_fail++; $display("FAIL b2b_tx_done pulses=%0d expected 2 at cycles 9 and 17", nd);
    end
  endtask

  task automatic test_backpressure();
    int nd;
    beat_t e;
    lg.delete(); sb.delete();
    in_value_LSBs = 32'hCAFE_F00D; in_value_MSBs = 32'h1234_5678;
    in_valid = 1'b1; pReady = 1'b1;
    push_frame(in_value_LSBs, in_value_MSBs);
    capture(1);
    in_valid = 1'b0;
    capture(3);
    pReady = 1'b0;
    capture(5);
    pReady = 1'b1;
    capture(8);
    nd = 0;
    foreach (lg[i]) begin
      if (lg[i].d) nd++;
      if (i >= 4 && i <= 8) begin
        n_checks++;
        if (lg[i].v !== 1'b1 || lg[i].l !== in_value_LSBs[15:12] || lg[i].m !== in_value_MSBs[15:12]) begin
          n_fail++; $display("FAIL stall_frozen cycle %0d v=%b l=%h m=%h expected 1/%h/%h",
                             i, lg[i].v, lg[i].l, lg[i].m, in_value_LSBs[15:12], in_value_MSBs[15:12]);
        end
      end
      if (lg[i].v && lg[i].r) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL stall_extra_beat at cycle %0d", i);
        end else begin
          e = sb.pop_front();
          if (lg[i].l !== e.l || lg[i].m !== e.m) begin
            n_fail++; $display("FAIL stall_beat cycle %0d got %h/%h expected %h/%h", i, lg[i].l, lg[i].m, e.l, e.m);
          end
        end
      end
    end
    n_checks++;
    if (nd !== 1 || sb.size() !== 0) begin
      n_fail++; $display("FAIL stall_complete tx_done=%0d left=%0d expected 1/0", nd, sb.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int nd;
    beat_t e;
    lg.delete(); sb.delete();
    in_value_LSBs = 32'h8765_4321; in_value_MSBs = 32'hFEDC_BA98;
    in_valid = 1'b1; pReady = 1'b1;
    push_frame(in_value_LSBs, in_value_MSBs);
    capture(1);
    in_valid = 1'b0;
    capture(5);
    for (int i = 1; i <= 5; i++) begin
      n_checks++;
      e = sb.pop_front();
      if (lg[i].l !== e.l || lg[i].m !== e.m) begin
        n_fail++; $display("FAIL rstmid_beat cycle %0d got %h/%h expected %h/%h", i, lg[i].l, lg[i].m, e.l, e.m);
      end
    end
    sb.delete();
    RESET_n = 1'b0;
    capture(1);
    n_checks++;
    if (lg[6].ir !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_in_ready_low got %b expected 0", lg[6].ir);
    end
    RESET_n = 1'b1;
    capture(3);
    nd = 0;
    foreach (lg[i]) if (lg[i].d) nd++;
    for (int i = 7; i <= 9; i++) begin
      n_checks++;
      if (lg[i].v !== 1'b0 || lg[i].l !== 4'h0 || lg[i].m !== 4'h0 || lg[i].ir !== 1'b1 || lg[i].p !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_after cycle %0d v=%b l=%h m=%h ir=%b p=%b expected 0/0/0/1/0",
                           i, lg[i].v, lg[i].l, lg[i].m, lg[i].ir, lg[i].p);
      end
    end
    n_checks++;
    if (nd !== 0) begin
      n_fail++; $display("FAIL rstmid_tx_done pulses=%0d expected 0", nd);
    end
  endtask

  task automatic test_load_refused();
    int nv, nd;
    beat_t e;
    lg.delete(); sb.delete();
    in_value_LSBs = 32'h0F1E_2D3C; in_value_MSBs = 32'h4B5A_6978;
    in_valid = 1'b1; pReady = 1'b1;
    push_frame(in_value_LSBs, in_value_MSBs);
    capture(1);
    in_valid = 1'b0;
    capture(2);
    in_value_LSBs = 32'hDEAD_BEEF; in_value_MSBs = 32'hBAAD_F00D;
    in_valid = 1'b1;
    capture(1);
    in_valid = 1'b0;
    capture(9);
    n_checks++;
    if (lg[3].ir !== 1'b0) begin
      n_fail++; $display("FAIL refused_in_ready got %b expected 0", lg[3].ir);
    end
    nv = 0; nd = 0;
    foreach (lg[i]) begin
      if (lg[i].v) nv++;
      if (lg[i].d) nd++;
      if (lg[i].v && lg[i].r) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL refused_extra_beat at cycle %0d", i);
        end else begin
          e = sb.pop_front();
          if (lg[i].l !== e.l || lg[i].m !== e.m) begin
            n_fail++; $display("FAIL refused_beat cycle %0d got %h/%h expected %h/%h", i, lg[i].l, lg[i].m, e.l, e.m);
          end
        end
      end
    end
    n_checks++;
    if (nv !== 8 || nd !== 1) begin
      n_fail++; $display("FAIL refused_frame valid=%0d tx_done=%0d expected 8/1", nv, nd);
    end
  endtask

`ifdef CHIP_TX_PARITY_EN
  task automatic test_parity();
    beat_t e;
    logic exp_p;
    lg.delete(); sb.delete();
    in_value_LSBs = 32'h0000_00F3; in_value_MSBs = 32'h0000_0001;
    in_valid = 1'b1; pReady = 1'b1;
    push_frame(in_value_LSBs, in_value_MSBs);
    capture(1);
    in_valid = 1'b0;
    capture(9);
    n_checks++;
    if (lg[1].p !== 1'b1 || lg[2].p !== 1'b0) begin
      n_fail++; $display("FAIL parity_known got %b,%b expected 1,0", lg[1].p, lg[2].p);
    end
    foreach (lg[i]) begin
      if (lg[i].v && lg[i].r && sb.size() != 0) begin
        e = sb.pop_front();
        exp_p = ^e.l ^ ^e.m;
        n_checks++;
        if (lg[i].p !== exp_p) begin
          n_fail++; $display("FAIL parity_beat cycle %0d got %b expected %b", i, lg[i].p, exp_p);
        end
      end else if (!lg[i].v) begin
        n_checks++;
        if (lg[i].p !== 1'b0) begin
          n_fail++; $display("FAIL parity_idle cycle %0d got %b expected 0", i, lg[i].p);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    test_load_refused();
`ifdef CHIP_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
